// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures i_Clk cycles between enable ticks, flags out-of-window periods and lost ticks.
// Optional running min/max of measured periods when TICK_PERIOD_MONITOR_MINMAX_EN is defined.
module tick_period_monitor #(
   parameter logic [23:0] EXPECTED_PERIOD = 24'd2500001,
   parameter logic [23:0] TOLERANCE       = 24'd16,
   parameter logic [23:0] TIMEOUT_CYCLES  = 24'd5000002
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_tick,
   input  logic        i_clear,
   output logic [23:0] o_period,
   output logic        o_period_valid,
   output logic        o_in_range,
   output logic        o_error,
   output logic        o_timeout,
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
   output logic [23:0] o_period_min,
   output logic [23:0] o_period_max,
`endif
   output logic        o_locked
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   // Window bounds in 25 bits so EXPECTED_PERIOD + TOLERANCE cannot overflow; lower bound clamps at 0.
   localparam logic [24:0] WIN_HI = {1'b0, EXPECTED_PERIOD} + {1'b0, TOLERANCE};
   localparam logic [24:0] WIN_LO = (TOLERANCE > EXPECTED_PERIOD) ? 25'd0
                                    : ({1'b0, EXPECTED_PERIOD} - {1'b0, TOLERANCE});
   localparam logic [23:0] CNT_MAX = 24'hFFFFFF;

   state_t      state_reg, state_next;
   logic [23:0] cnt_reg, cnt_next;
   logic [23:0] period_reg, period_next;
   logic        valid_reg, valid_next;
   logic        in_range_reg, in_range_next;
   logic        error_reg, error_next;
   logic        timeout_reg, timeout_next;
   logic        in_window;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
   logic [23:0] min_reg, min_next;
   logic [23:0] max_reg, max_next;
`endif

   assign in_window = ({1'b0, cnt_reg} >= WIN_LO) && ({1'b0, cnt_reg} <= WIN_HI);

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      period_next   = period_reg;
      valid_next    = 1'b0;
      in_range_next = in_range_reg;
      error_next    = error_reg;
      timeout_next  = timeout_reg;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
      min_next      = min_reg;
      max_next      = max_reg;
`endif
      if (i_clear) begin
         // Clear has priority over a coincident tick; the last period value is kept.
         state_next    = IDLE;
         cnt_next      = 24'd0;
         in_range_next = 1'b0;
         error_next    = 1'b0;
         timeout_next  = 1'b0;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
         min_next      = CNT_MAX;
         max_next      = 24'd0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_tick) begin
                  state_next = MEASURE;
                  cnt_next   = 24'd1;
               end
            end
            MEASURE: begin
               if (i_tick) begin
                  period_next   = cnt_reg;
                  valid_next    = 1'b1;
                  in_range_next = in_window;
                  error_next    = error_reg | ~in_window;
                  cnt_next      = 24'd1;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
                  if (cnt_reg < min_reg) min_next = cnt_reg;
                  if (cnt_reg > max_reg) max_next = cnt_reg;
`endif
               end else if (cnt_reg == TIMEOUT_CYCLES) begin
                  timeout_next = 1'b1;
                  state_next   = TIMEOUT;
               end else if (cnt_reg != CNT_MAX) begin
                  cnt_next = cnt_reg + 24'd1;
               end
            end
            TIMEOUT: begin
               // Counter stays frozen; the next tick re-arms without reporting.
               if (i_tick) begin
                  state_next = MEASURE;
                  cnt_next   = 24'd1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = 24'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= 24'd0;
         period_reg   <= 24'd0;
         valid_reg    <= 1'b0;
         in_range_reg <= 1'b0;
         error_reg    <= 1'b0;
         timeout_reg  <= 1'b0;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
         min_reg      <= CNT_MAX;
         max_reg      <= 24'd0;
`endif
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         period_reg   <= period_next;
         valid_reg    <= valid_next;
         in_range_reg <= in_range_next;
         error_reg    <= error_next;
         timeout_reg  <= timeout_next;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
         min_reg      <= min_next;
         max_reg      <= max_next;
`endif
      end
   end

   assign o_period       = period_reg;
   assign o_period_valid = valid_reg;
   assign o_in_range     = in_range_reg;
   assign o_error        = error_reg;
   assign o_timeout      = timeout_reg;
   assign o_locked       = (state_reg == MEASURE) && in_range_reg;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
   assign o_period_min   = min_reg;
   assign o_period_max   = max_reg;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// Testbench for tick_period_monitor (EXPECTED_PERIOD=10, TOLERANCE=1, TIMEOUT_CYCLES=20).
// Expected periods are queued when ticks are driven and popped when o_period_valid strobes.
module tb_tick_period_monitor;

   localparam int EXP = 10;
   localparam int TOL = 1;
   localparam int TO  = 20;

   logic        i_Clk;
   logic        i_Rst_n;
   logic        i_tick;
   logic        i_clear;
   logic [23:0] o_period;
   logic        o_period_valid;
   logic        o_in_range;
   logic        o_error;
   logic        o_timeout;
   logic        o_locked;
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
   logic [23:0] o_period_min;
   logic [23:0] o_period_max;
`endif

   tick_period_monitor #(
      .EXPECTED_PERIOD(24'd10),
      .TOLERANCE      (24'd1),
      .TIMEOUT_CYCLES (24'd20)
   ) dut (
      .i_Clk         (i_Clk),
      .i_Rst_n       (i_Rst_n),
      .i_tick        (i_tick),
      .i_clear       (i_clear),
      .o_period      (o_period),
      .o_period_valid(o_period_valid),
      .o_in_range    (o_in_range),
      .o_error       (o_error),
      .o_timeout     (o_timeout),
`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
      .o_period_min  (o_period_min),
      .o_period_max  (o_period_max),
`endif
      .o_locked      (o_locked)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   int vectors_applied = 0;
   int miscompares     = 0;

   // Scoreboard entries are {expected in_range, expected period}.
   logic [24:0] sb_q[$];

   // Reference model state: cycle index of the last tick, armed, and "next tick is not reported".
   int   cyc      = 0;
   int   m_last   = 0;
   logic m_armed  = 1'b0;
   logic m_silent = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h at %0t", tag, got, $time);
      end
   endtask

   task automatic push_period(input int p);
      logic inr;
      inr = (p >= EXP - TOL) && (p <= EXP + TOL);
      sb_q.push_back({inr, 24'(p)});
   endtask

   // Drive one clock edge with the given tick/clear and advance the model.
   task automatic step(input logic t, input logic c);
      i_tick  = t;
      i_clear = c;
      if (c) begin
         m_armed  = 1'b0;
         m_silent = 1'b0;
      end else begin
         if (m_armed && !m_silent && !t && (cyc - m_last == TO)) m_silent = 1'b1;
         if (t) begin
            if (m_armed && !m_silent) push_period(cyc - m_last);
            m_armed  = 1'b1;
            m_silent = 1'b0;
            m_last   = cyc;
         end
      end
      @(posedge i_Clk);
      #1;
      cyc++;
      i_tick  = 1'b0;
      i_clear = 1'b0;
   endtask

   // Tick n edges after the previous one.
   task automatic gap(input int n);
      for (int k = 0; k < n - 1; k++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
   endtask

   always @(negedge i_Clk) begin
      if (o_period_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_strobe", 32'(o_period), 32'hFFFFFFFF);
         end else begin
            logic [24:0] e;
            e = sb_q.pop_front();
            check_eq("period", 32'(o_period), 32'(e[23:0]));
            check_eq("in_range", 32'(o_in_range), 32'(e[24]));
         end
      end
   end

   initial begin
      i_Rst_n = 1'b0;
      i_tick  = 1'b0;
      i_clear = 1'b0;
      #12;
      i_Rst_n = 1'b1;
      @(posedge i_Clk);
      #1;
      check_eq("rst_period", 32'(o_period), 0);
      check_eq("rst_valid", 32'(o_period_valid), 0);
      check_eq("rst_flags", 32'({o_in_range, o_error, o_timeout, o_locked}), 0);

      // 1: five ticks 10 apart
      step(1'b1, 1'b0);
      check_eq("s1_no_first_strobe", 32'(o_period_valid), 0);
      check_eq("s1_locked_first", 32'(o_locked), 0);
      gap(10);
      check_eq("s1_locked", 32'(o_locked), 1);
      for (int k = 0; k < 3; k++) gap(10);
      check_eq("s1_error", 32'(o_error), 0);
      check_eq("s1_locked_end", 32'(o_locked), 1);

      // 2: intervals 10, 12, 9
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      gap(10);
      check_eq("s2_error_10", 32'(o_error), 0);
      gap(12);
      check_eq("s2_error_12", 32'(o_error), 1);
      check_eq("s2_locked_12", 32'(o_locked), 0);
      gap(9);
      check_eq("s2_error_sticky", 32'(o_error), 1);
      check_eq("s2_locked_9", 32'(o_locked), 1);

      // 3: timeout exactly TO cycles after the last tick
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      for (int k = 0; k < TO - 1; k++) step(1'b0, 1'b0);
      check_eq("s3_timeout_early", 32'(o_timeout), 0);
      step(1'b0, 1'b0);
      check_eq("s3_timeout", 32'(o_timeout), 1);
      check_eq("s3_locked", 32'(o_locked), 0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check_eq("s3_rearm_no_strobe", 32'(o_period_valid), 0);
      gap(10);
      check_eq("s3_timeout_sticky", 32'(o_timeout), 1);

      // tick coincident with timeout: period 20 reported, error set, no timeout
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      gap(TO);
      check_eq("tie_error", 32'(o_error), 1);
      check_eq("tie_timeout", 32'(o_timeout), 0);

      // 4: clear coincident with tick while error is set
      check_eq("s4_error_pre", 32'(o_error), 1);
      step(1'b1, 1'b1);
      check_eq("s4_valid", 32'(o_period_valid), 0);
      check_eq("s4_error", 32'(o_error), 0);
      check_eq("s4_period_kept", 32'(o_period), TO);
      gap(3);
      check_eq("s4_idle_no_strobe", 32'(o_period_valid), 0);
      gap(10);

      // 5: async reset mid-interval
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
      check_eq("s5_locked_pre", 32'(o_locked), 1);
      #2;
      i_Rst_n = 1'b0;
      #1;
      check_eq("s5_rst_period", 32'(o_period), 0);
      check_eq("s5_rst_flags", 32'({o_period_valid, o_in_range, o_error, o_timeout, o_locked}), 0);
      m_armed  = 1'b0;
      m_silent = 1'b0;
      step(1'b0, 1'b0);
      #3;
      i_Rst_n = 1'b1;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check_eq("s5_first_tick_no_strobe", 32'(o_period_valid), 0);
      gap(10);

`ifdef TICK_PERIOD_MONITOR_MINMAX_EN
      // 6: running min/max
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      gap(11);
      gap(9);
      gap(10);
      check_eq("s6_min", 32'(o_period_min), 9);
      check_eq("s6_max", 32'(o_period_max), 11);
      step(1'b0, 1'b1);
      check_eq("s6_min_clr", 32'(o_period_min), 32'h00FFFFFF);
      check_eq("s6_max_clr", 32'(o_period_max), 0);
`endif

      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check_eq("sb_pending", 32'(sb_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Receive-side checker for the single-cycle clock-enable ticks made by the team's clock dividers.
- Measures the number of i_Clk cycles between consecutive ticks and reports that period.
- Flags periods outside a tolerance window, and flags a missing tick stream.
- Sits beside any tick consumer, such as a debouncer, blinker or UART baud tick, as a built-in health monitor. It does the reverse of the divider: it turns pulses back into a count.

Parameters:
- EXPECTED_PERIOD, 24'd2500001: nominal cycles between ticks. This is the divider factor + 1.
- TOLERANCE, 24'd16: allowed absolute deviation from EXPECTED_PERIOD, inclusive.
- TIMEOUT_CYCLES, 24'd5000002: number of cycles without a tick that raises a timeout. Must be greater than EXPECTED_PERIOD + TOLERANCE.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_tick  input  1  enable pulse under test. One cycle per tick; consecutive high cycles count as separate ticks.
- i_clear  input  1  synchronous clear of the flags; returns the block to IDLE.
- o_period  output  24  last measured period.
- o_period_valid  output  1  one-cycle strobe when o_period updates.
- o_in_range  output  1  last measured period lay within EXPECTED_PERIOD ± TOLERANCE.
- o_error  output  1  sticky: some measured period was out of range.
- o_timeout  output  1  sticky: TIMEOUT_CYCLES elapsed with no tick.
- o_locked  output  1  high while in MEASURE and the last period was in range.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-low on i_Rst_n; every register clears immediately.
  - Reset values: all outputs 0, state IDLE, cycle counter 0.
- Internal counter:
  - cnt is 24 bits.
  - It loads 1 on the cycle after a tick, then increments each cycle.
  - It saturates at 24'hFFFFFF and never wraps.
- Period definition: ticks on cycles t and t+N give period N. Back-to-back ticks give N=1.
- State machine:
  - IDLE: wait for i_tick. On a tick, go to MEASURE with cnt := 1. Nothing is reported for the first tick.
  - MEASURE, tick this cycle:
    - Next cycle: o_period := cnt, o_period_valid := 1, o_in_range := in-window compare.
    - o_error is set if the period is out of range; it is never cleared here.
    - cnt := 1.
  - MEASURE, no tick: if cnt == TIMEOUT_CYCLES, then o_timeout := 1 and go to TIMEOUT.
  - TIMEOUT: cnt frozen. The next tick goes to MEASURE with cnt := 1, without reporting a period. o_timeout stays set.
- Latency: exactly 1 cycle from the tick cycle to the o_period_valid strobe.
- In-range compare:
  - Condition: EXPECTED_PERIOD − TOLERANCE ≤ period ≤ EXPECTED_PERIOD + TOLERANCE, unsigned.
  - Compute in 25 bits. The lower bound clamps at 0 when TOLERANCE > EXPECTED_PERIOD.
- o_locked = (state == MEASURE) && o_in_range.
- i_clear:
  - Effect next cycle: o_error, o_timeout, o_in_range, o_locked and o_period_valid go to 0; state goes to IDLE; cnt goes to 0.
  - o_period keeps its last value.
- i_clear and i_tick in the same cycle: clear wins and the tick is ignored.
- Reset mid-measurement: the measurement is discarded with no strobe. The first tick after reset only arms the block.
- Timeout and tick in the same cycle (cnt == TIMEOUT_CYCLES): the tick wins; the period is reported and is out of range by construction, so o_error is set and o_timeout is not set.

Optional Feature:
- Macro: TICK_PERIOD_MONITOR_MINMAX_EN.
- When defined:
  - Adds outputs o_period_min[23:0] (reset 24'hFFFFFF) and o_period_max[23:0] (reset 0).
  - Both update on every o_period_valid with the running min and max.
  - Both are reset by i_clear and i_Rst_n.
- When undefined: these ports and registers do not exist, and the port list is exactly as above.

Test Plan:
All scenarios use EXPECTED_PERIOD=10, TOLERANCE=1, TIMEOUT_CYCLES=20.
1. Ticks every 10 cycles, 5 ticks → first tick gives no strobe; 4 strobes follow, each with o_period=10 and o_in_range=1; o_locked=1 after the second tick; o_error=0.
2. Tick intervals 10, 12, 9 → periods 10, 12, 9; o_in_range reads 1, 0, 1; o_error goes to 1 at the 12 and stays 1; o_locked is 0 only after the 12.
3. Tick, then silence for 25 cycles → o_timeout=1 exactly 20 cycles after the tick; the next tick produces no strobe; the tick after that reports its true period.
4. i_clear asserted in the same cycle as a tick while o_error=1 → no strobe; o_error=0; state IDLE; the next two ticks 10 apart give o_period=10.
5. i_Rst_n pulsed low asynchronously mid-interval (5 cycles after a tick) → all outputs 0 immediately; a tick after release produces no strobe.
6. With TICK_PERIOD_MONITOR_MINMAX_EN, intervals 11, 9, 10 → o_period_min=9, o_period_max=11; after i_clear they read FFFFFF and 0.
